q_loop_sequencer: RTL and testbench

Measurement sequencer for the Q control loop. It paces the charge-measurement front end by issuing `start` pulses after a settling interval whenever the loop is enabled. It watches for measurement completion with a timeout and restarts settling whenever the current reference changes. It also declares loop lock once the measured Q stays within tolerance of the setpoint for a programmable number of consecutive measurements.

---
 rtl/q_loop_sequencer.sv | 162 ++++++++++++++++
 tb/tb_q_loop_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_loop_sequencer.sv
`timescale 1ns/1ps
// Q control loop measurement sequencer: paces measurement starts after i_ref
// settling, supervises completion with a timeout, and declares lock.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | loop disabled, waiting for enable
// S_SETTLE | counting down stable-i_ref cycles, restarts on i_ref change
// S_START  | one-cycle start pulse to the measurement front end
// S_WAIT   | waiting for ready, bounded by the timeout counter
// S_EVAL   | compare captured Q against setpoint, update lock tracking
// S_FAULT  | measurement timed out, held until enable drops
module q_loop_sequencer #(
   parameter int BUS_WIDTH      = 10,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TOL            = 1,
   parameter int LOCK_COUNT     = 4,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 ready,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic [BUS_WIDTH-1:0] q_measured,
   input  logic [BUS_WIDTH-1:0] q_desired,
   output logic                 start,
   output logic                 busy,
   output logic                 locked,
   output logic                 timeout_err,
   output logic [CNT_WIDTH-1:0] meas_count
);

   localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
   localparam int LCK_W   = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

   localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES);
   localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES);
   localparam logic [LCK_W-1:0] LOCK_MAX   = LCK_W'(LOCK_COUNT);
   localparam logic [31:0]      TOL_U      = 32'(TOL);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_START, S_WAIT, S_EVAL, S_FAULT
   } state_t;

   state_t               state;
   logic [TMR_W-1:0]     timer;
   logic [BUS_WIDTH-1:0] shadow;
   logic [BUS_WIDTH-1:0] q_cap;
   logic [LCK_W-1:0]     lock_cnt;

   // One extra bit so the absolute difference never wraps.
   logic [BUS_WIDTH:0] q_a, q_b, diff;
   logic               in_tol;
   logic [LCK_W-1:0]   lock_inc;

   assign q_a      = {1'b0, q_cap};
   assign q_b      = {1'b0, q_desired};
   assign diff     = (q_a >= q_b) ? (q_a - q_b) : (q_b - q_a);
   assign in_tol   = (32'(diff) <= TOL_U);
   assign lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         shadow      <= '0;
         q_cap       <= '0;
         lock_cnt    <= '0;
         start       <= 1'b0;
         busy        <= 1'b0;
         locked      <= 1'b0;
         timeout_err <= 1'b0;
         meas_count  <= '0;
      end else begin
         start <= 1'b0;
         if (!enable) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            locked      <= 1'b0;
            lock_cnt    <= '0;
            timeout_err <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  // busy follows one edge later than the enable acceptance
                  busy   <= 1'b0;
                  shadow <= i_ref;
                  if (SETTLE_CYCLES == 0) begin
                     state <= S_START;
                     start <= 1'b1;
                     timer <= TIMEOUT_LD;
                  end else begin
                     state <= S_SETTLE;
                     timer <= SETTLE_LD;
                  end
               end
               S_SETTLE: begin
                  busy <= 1'b1;
                  if (i_ref != shadow) begin
                     shadow <= i_ref;
                     timer  <= SETTLE_LD;
                  end else if (timer == '0) begin
                     state <= S_START;
                     start <= 1'b1;
                     timer <= TIMEOUT_LD;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               S_START: begin
                  busy  <= 1'b1;
                  state <= S_WAIT;
               end
               S_WAIT: begin
                  if (ready) begin
                     busy  <= 1'b1;
                     q_cap <= q_measured;
                     state <= S_EVAL;
                  end else if (timer == TMR_W'(1)) begin
                     busy        <= 1'b0;
                     state       <= S_FAULT;
                     timeout_err <= 1'b1;
                     locked      <= 1'b0;
                     lock_cnt    <= '0;
                  end else begin
                     busy  <= 1'b1;
                     timer <= timer - 1'b1;
                  end
               end
               S_EVAL: begin
                  busy <= 1'b1;
                  if (meas_count != '1)
                     meas_count <= meas_count + 1'b1;
                  if (in_tol) begin
                     lock_cnt <= lock_inc;
                     locked   <= (lock_inc == LOCK_MAX);
                  end else begin
                     lock_cnt <= '0;
                     locked   <= 1'b0;
                  end
                  state  <= S_SETTLE;
                  shadow <= i_ref;
                  timer  <= SETTLE_LD;
               end
               S_FAULT: begin
                  busy        <= 1'b0;
                  locked      <= 1'b0;
                  timeout_err <= 1'b1;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_q_loop_sequencer.sv
`timescale 1ns/1ps
// Directed bench for q_loop_sequencer; a second instance with a 3-bit
// measurement counter shares the stimulus to observe counter saturation.
module tb_q_loop_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       ready = 1'b0;
   logic [9:0] i_ref = '0;
   logic [9:0] q_measured = '0;
   logic [9:0] q_desired = '0;
   logic       start, busy, locked, timeout_err;
   logic [7:0] meas_count;
   logic       s2_start, s2_busy, s2_locked, s2_timeout_err;
   logic [2:0] s2_meas_count;

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   q_loop_sequencer dut (
      .clk(clk), .rst(rst), .enable(enable), .ready(ready), .i_ref(i_ref),
      .q_measured(q_measured), .q_desired(q_desired), .start(start), .busy(busy),
      .locked(locked), .timeout_err(timeout_err), .meas_count(meas_count)
   );

   q_loop_sequencer #(.CNT_WIDTH(3)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .ready(ready), .i_ref(i_ref),
      .q_measured(q_measured), .q_desired(q_desired), .start(s2_start), .busy(s2_busy),
      .locked(s2_locked), .timeout_err(s2_timeout_err), .meas_count(s2_meas_count)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_start(input int max, output int n, output bit seen);
      n = 0;
      seen = 1'b0;
      while (!seen && n <= max) begin
         if (start === 1'b1) seen = 1'b1;
         else begin
            step(1);
            n++;
         end
      end
   endtask

   // One measurement with ready one cycle into WAIT; ends after the EVAL edge.
   task automatic do_meas(input logic [9:0] q);
      int n;
      bit seen;
      wait_start(400, n, seen);
      tests++;
      if (!seen) begin $display("FAIL meas_start: start=0 after %0d cycles, required 1", n); fails++; end
      step(1);
      tests++;
      if (start !== 1'b0) begin $display("FAIL start_width: start=%b, required 0", start); fails++; end
      ready = 1'b1;
      q_measured = q;
      step(1);
      ready = 1'b0;
      step(1);
      exp_cnt++;
   endtask

   task automatic check_cnt(input string name);
      int exp2;
      exp2 = (exp_cnt > 7) ? 7 : exp_cnt;
      tests++;
      if (meas_count !== 8'(exp_cnt)) begin
         $display("FAIL %s meas_count: got %0d required %0d", name, meas_count, exp_cnt); fails++;
      end
      tests++;
      if (s2_meas_count !== 3'(exp2)) begin
         $display("FAIL %s sat_count: got %0d required %0d", name, s2_meas_count, exp2); fails++;
      end
   endtask

   task automatic test_reset;
      enable = 1'b1;
      ready  = 1'b1;
      step(3);
      tests++;
      if ({start, busy, locked, timeout_err, meas_count} !== 12'h0 ||
          {s2_start, s2_busy, s2_locked, s2_timeout_err, s2_meas_count} !== 7'h0) begin
         $display("FAIL reset_outputs: got %b %b %b %b %0d, required all 0",
                  start, busy, locked, timeout_err, meas_count); fails++;
      end
      enable = 1'b0;
      ready  = 1'b0;
      rst    = 1'b1;
      step(2);
      tests++;
      if ({start, busy, locked, timeout_err, meas_count} !== 12'h0) begin
         $display("FAIL idle_outputs: got %b %b %b %b %0d, required all 0",
                  start, busy, locked, timeout_err, meas_count); fails++;
      end
   endtask

   task automatic test_basic_pulse;
      int early = 0;
      i_ref  = 10'd100;
      enable = 1'b1;
      step(1);
      for (int i = 1; i <= 16; i++) begin
         step(1);
         if (start === 1'b1) early++;
         if (i == 1) begin
            tests++;
            if (busy !== 1'b1) begin $display("FAIL busy_rise: busy=%b, required 1", busy); fails++; end
         end
      end
      tests++;
      if (early != 0) begin $display("FAIL start_early: %0d start cycles, required 0", early); fails++; end
      step(1);
      tests++;
      if (start !== 1'b1) begin $display("FAIL start_at_17: start=%b, required 1", start); fails++; end
   endtask

   task automatic test_lock;
      logic [9:0] qs [5] = '{10'd501, 10'd499, 10'd500, 10'd500, 10'd503};
      logic       exp_lock [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      q_desired = 10'd500;
      for (int i = 0; i < 5; i++) begin
         do_meas(qs[i]);
         tests++;
         if (locked !== exp_lock[i]) begin
            $display("FAIL lock_%0d: locked=%b required %b", i, locked, exp_lock[i]); fails++;
         end
         check_cnt("lock");
      end
   endtask

   task automatic test_period;
      int n;
      bit seen;
      wait_start(100, n, seen);
      tests++;
      if (!seen || n != 17) begin $display("FAIL period: start after %0d cycles, required 17", n); fails++; end
      do_meas(10'd500);
   endtask

   task automatic test_settle_restart;
      int n;
      bit seen;
      step(5);
      i_ref = 10'd200;
      wait_start(100, n, seen);
      tests++;
      if (!seen || n != 18) begin $display("FAIL settle_restart: start after %0d cycles, required 18", n); fails++; end
      do_meas(10'd500);
      check_cnt("restart");
   endtask

   task automatic test_toggle;
      int seen_starts = 0;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 10; i++) begin
            step(1);
            if (start === 1'b1) seen_starts++;
         end
         i_ref = i_ref + 10'd1;
      end
      tests++;
      if (seen_starts != 0) begin $display("FAIL toggle_no_start: %0d starts, required 0", seen_starts); fails++; end
      do_meas(10'd500);
      check_cnt("toggle");
   endtask

   task automatic test_stale_ready;
      int n;
      bit seen;
      wait_start(100, n, seen);
      ready = 1'b1;
      q_measured = 10'd0;
      step(1);
      ready = 1'b0;
      step(3);
      tests++;
      if (meas_count !== 8'(exp_cnt) || busy !== 1'b1) begin
         $display("FAIL stale_ready: meas_count=%0d busy=%b, required %0d 1", meas_count, busy, exp_cnt); fails++;
      end
      ready = 1'b1;
      q_measured = 10'd500;
      step(1);
      ready = 1'b0;
      step(1);
      exp_cnt++;
      check_cnt("stale");
      tests++;
      if (locked !== 1'b1) begin $display("FAIL lock_reacquire: locked=%b required 1", locked); fails++; end
      ready = 1'b1;
      step(5);
      ready = 1'b0;
      do_meas(10'd501);
      check_cnt("settle_ready");
   endtask

   task automatic test_timeout_ready_last;
      int n;
      bit seen;
      wait_start(100, n, seen);
      step(255);
      ready = 1'b1;
      q_measured = 10'd500;
      step(1);
      ready = 1'b0;
      tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL ready_wins: timeout_err=%b busy=%b, required 0 1", timeout_err, busy); fails++;
      end
      step(1);
      exp_cnt++;
      check_cnt("ready_last");
      tests++;
      if (locked !== 1'b1) begin $display("FAIL lock_hold: locked=%b required 1", locked); fails++; end
   endtask

   task automatic test_timeout;
      int n, extra = 0;
      bit seen;
      wait_start(100, n, seen);
      step(255);
      tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL timeout_early: timeout_err=%b busy=%b, required 0 1", timeout_err, busy); fails++;
      end
      step(1);
      tests++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || locked !== 1'b0) begin
         $display("FAIL fault_entry: timeout_err=%b busy=%b locked=%b, required 1 0 0",
                  timeout_err, busy, locked); fails++;
      end
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (start === 1'b1) extra++;
      end
      tests++;
      if (extra != 0 || timeout_err !== 1'b1) begin
         $display("FAIL fault_hold: starts=%0d timeout_err=%b, required 0 1", extra, timeout_err); fails++;
      end
      enable = 1'b0;
      step(1);
      tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL fault_clear: timeout_err=%b busy=%b, required 0 0", timeout_err, busy); fails++;
      end
      check_cnt("timeout");
   endtask

   task automatic test_disable_mid;
      int n, extra = 0;
      bit seen;
      enable = 1'b1;
      wait_start(100, n, seen);
      tests++;
      if (!seen || n != 18) begin $display("FAIL idle_restart: start after %0d cycles, required 18", n); fails++; end
      for (int i = 0; i < 4; i++) do_meas(10'd500);
      tests++;
      if (locked !== 1'b1) begin $display("FAIL relock: locked=%b required 1", locked); fails++; end
      wait_start(100, n, seen);
      step(4);
      enable = 1'b0;
      step(1);
      tests++;
      if (busy !== 1'b0 || locked !== 1'b0 || start !== 1'b0) begin
         $display("FAIL disable_mid: busy=%b locked=%b start=%b, required 0 0 0", busy, locked, start); fails++;
      end
      ready = 1'b1;
      q_measured = 10'd500;
      step(1);
      ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (start === 1'b1 || busy === 1'b1) extra++;
      end
      tests++;
      if (extra != 0 || locked !== 1'b0) begin
         $display("FAIL late_ready: active cycles=%0d locked=%b, required 0 0", extra, locked); fails++;
      end
      check_cnt("disable");
   endtask

   task automatic test_overflow;
      q_desired = 10'd1023;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_meas(10'd0);
         tests++;
         if (locked !== 1'b0) begin $display("FAIL diff_wrap_%0d: locked=%b required 0", i, locked); fails++; end
      end
      check_cnt("overflow");
   endtask

   initial begin
      test_reset();
      test_basic_pulse();
      test_lock();
      test_period();
      test_settle_restart();
      test_toggle();
      test_stale_ready();
      test_timeout_ready_last();
      test_timeout();
      test_disable_mid();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
